// File: rtl/mini_cpu_pkg.sv
// Shared opcode, state and default-parameter definitions for the mini CPU core.
package mini_cpu_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 4;
  localparam int unsigned DefImmW  = 7;

  typedef enum logic [2:0] {
    OpLoad    = 3'd0,
    OpAdd     = 3'd1,
    OpAddi    = 3'd2,
    OpSub     = 3'd3,
    OpSubi    = 3'd4,
    OpMul     = 3'd5,
    OpClear   = 3'd6,
    OpDisplay = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRdA     = 3'd1,
    StRdB     = 3'd2,
    StExec    = 3'd3,
    StWrite   = 3'd4,
    StClear   = 3'd5,
    StDispRd  = 3'd6,
    StDispReq = 3'd7
  } state_e;

  // Register-register ops fetch two operands; all other ALU ops use the immediate.
  function automatic logic op_uses_rs2(opcode_e op);
    return (op == OpAdd) || (op == OpSub);
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: synchronous read (data one cycle after address), one write port, no reset.
module cpu_regfile
  import mini_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Non-blocking read of mem_q returns the pre-write value on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mini_cpu_core.sv
// Multi-cycle mini CPU: instruction handshake, ALU, clear sweep and display handshake.
module mini_cpu_core
  import mini_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned IMM_W  = DefImmW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [IMM_W-1:0]  imm,
  output logic              disp_req,
  input  logic              disp_ack,
  output logic [2:0]        disp_opcode,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic [DATA_W-1:0] result,
  output logic              flag_ovf,
  output logic              flag_zero,
  output logic              busy
);

  localparam int unsigned Msb = DATA_W - 1;

  state_e              state_q;
  opcode_e             op_q;
  logic [ADDR_W-1:0]   rd_q, rs1_q, rs2_q, clr_cnt_q;
  logic [IMM_W-1:0]    imm_q;
  logic [DATA_W-1:0]   a_q, result_q, disp_data_q;
  logic                ovf_q, zero_q, clr_disp_q, disp_req_q;
  logic [ADDR_W-1:0]   disp_addr_q;
  logic [2:0]          disp_op_q;

  logic [DATA_W-1:0]   imm_ext, op_a, op_b, alu_res;
  logic                alu_ovf;
  logic [2*DATA_W-1:0] prod;

  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr, rf_raddr;
  logic [DATA_W-1:0]   rf_wdata, rf_rdata;

  assign imm_ext = DATA_W'(imm_q);

  // Two-operand ops hold rs1 in a_q while rs2 arrives; immediate ops use rs1 straight from the RF.
  always_comb begin
    op_a    = op_uses_rs2(op_q) ? a_q : rf_rdata;
    op_b    = op_uses_rs2(op_q) ? rf_rdata : imm_ext;
    prod    = '0;
    alu_res = imm_ext;
    alu_ovf = 1'b0;
    case (op_q)
      OpAdd, OpAddi: begin
        alu_res = op_a + op_b;
        alu_ovf = (op_a[Msb] == op_b[Msb]) && (alu_res[Msb] != op_a[Msb]);
      end
      OpSub, OpSubi: begin
        alu_res = op_a - op_b;
        alu_ovf = (op_a[Msb] != op_b[Msb]) && (alu_res[Msb] != op_a[Msb]);
      end
      OpMul: begin
        prod    = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
        alu_res = prod[DATA_W-1:0];
        alu_ovf = |prod[2*DATA_W-1:DATA_W];
      end
      default: begin
        alu_res = imm_ext;
        alu_ovf = 1'b0;
      end
    endcase
  end

  always_comb begin
    unique case (state_q)
      StRdA:   rf_raddr = rs1_q;
      StRdB:   rf_raddr = rs2_q;
      default: rf_raddr = rd_q;
    endcase
  end

  // en=0 in WRITE is an abort, so the pending write is dropped.
  assign rf_we    = !reset && ((state_q == StClear) || ((state_q == StWrite) && en));
  assign rf_waddr = (state_q == StClear) ? clr_cnt_q : rd_q;
  assign rf_wdata = (state_q == StClear) ? '0 : ((op_q == OpLoad) ? imm_ext : result_q);

  cpu_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk_i   (clk),
    .we_i    (rf_we),
    .waddr_i (rf_waddr),
    .wdata_i (rf_wdata),
    .raddr_i (rf_raddr),
    .rdata_o (rf_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StClear;
      clr_cnt_q   <= '0;
      clr_disp_q  <= 1'b0;
      op_q        <= OpLoad;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      a_q         <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      disp_req_q  <= 1'b0;
      disp_addr_q <= '0;
      disp_data_q <= '0;
      disp_op_q   <= '0;
    end else if (!en && (state_q != StIdle) && (state_q != StClear)) begin
      state_q    <= StClear;
      clr_cnt_q  <= '0;
      clr_disp_q <= 1'b0;
      disp_req_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (instr_valid && en) begin
            op_q  <= opcode_e'(opcode);
            rd_q  <= rd;
            rs1_q <= rs1;
            rs2_q <= rs2;
            imm_q <= imm;
            unique case (opcode_e'(opcode))
              OpLoad:                             state_q <= StWrite;
              OpAdd, OpSub, OpAddi, OpSubi, OpMul: state_q <= StRdA;
              OpClear: begin
                state_q    <= StClear;
                clr_cnt_q  <= '0;
                clr_disp_q <= 1'b1;
              end
              OpDisplay:                          state_q <= StDispRd;
            endcase
          end
        end
        StRdA:   state_q <= op_uses_rs2(op_q) ? StRdB : StExec;
        StRdB: begin
          a_q     <= rf_rdata;
          state_q <= StExec;
        end
        StExec: begin
          result_q <= alu_res;
          ovf_q    <= alu_ovf;
          zero_q   <= (alu_res == '0);
          state_q  <= StWrite;
        end
        StWrite: begin
          if (op_q == OpLoad) begin
            result_q <= imm_ext;
            ovf_q    <= 1'b0;
            zero_q   <= (imm_ext == '0);
          end
          state_q <= StDispRd;
        end
        StClear: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) begin
            state_q <= clr_disp_q ? StDispRd : StIdle;
          end
        end
        StDispRd: state_q <= StDispReq;
        // First DISP_REQ cycle captures the read data; the request then holds until ack.
        StDispReq: begin
          if (!disp_req_q) begin
            disp_req_q  <= 1'b1;
            disp_addr_q <= rd_q;
            disp_data_q <= rf_rdata;
            disp_op_q   <= op_q;
          end else if (disp_ack) begin
            disp_req_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
      endcase
    end
  end

  assign instr_ready = (state_q == StIdle) && en;
  assign busy        = (state_q != StIdle);
  assign disp_req    = disp_req_q;
  assign disp_addr   = disp_addr_q;
  assign disp_data   = disp_data_q;
  assign disp_opcode = disp_op_q;
  assign result      = result_q;
  assign flag_ovf    = ovf_q;
  assign flag_zero   = zero_q;

endmodule

// File: tb/tb_mini_cpu_core.sv
// Directed self-checking bench for mini_cpu_core with hand-computed expected values.
module tb_mini_cpu_core;
  import mini_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, en, instr_valid, instr_ready;
  logic [2:0]  opcode;
  logic [3:0]  rd, rs1, rs2;
  logic [6:0]  imm;
  logic        disp_req, disp_ack;
  logic [2:0]  disp_opcode;
  logic [3:0]  disp_addr;
  logic [15:0] disp_data, result;
  logic        flag_ovf, flag_zero, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mini_cpu_core #(
    .DATA_W (16),
    .ADDR_W (4),
    .IMM_W  (7)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .imm         (imm),
    .disp_req    (disp_req),
    .disp_ack    (disp_ack),
    .disp_opcode (disp_opcode),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data),
    .result      (result),
    .flag_ovf    (flag_ovf),
    .flag_zero   (flag_zero),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one instruction and wait for its display request; latency counted in cycles after accept.
  task automatic do_instr(input logic [2:0] op, input logic [3:0] d, input logic [3:0] s1,
                          input logic [3:0] s2, input logic [6:0] im, input int lat,
                          input logic [15:0] data);
    int n;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready", instr_ready, 1);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; imm = im;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!disp_req && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, lat);
    check("disp_addr", disp_addr, d);
    check("disp_data", disp_data, data);
    check("disp_opcode", disp_opcode, op);
  endtask

  task automatic ack();
    disp_ack = 1'b1;
    @(negedge clk);
    disp_ack = 1'b0;
    check("req_drop", disp_req, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic flags(input logic [15:0] res, input logic ovf, input logic zero);
    check("result", result, res);
    check("flag_ovf", flag_ovf, ovf);
    check("flag_zero", flag_zero, zero);
  endtask

  task automatic count_sweep(input string tag);
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, n, 16);
  endtask

  initial begin
    int  n;
    logic saw_req;
    reset = 1'b1; en = 1'b1; instr_valid = 1'b0; disp_ack = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (2) @(negedge clk);
    flags(16'd0, 1'b0, 1'b0);
    check("rst_ready", instr_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_req", disp_req, 0);
    check("rst_daddr", disp_addr, 0);
    check("rst_ddata", disp_data, 0);
    check("rst_dop", disp_opcode, 0);
    reset = 1'b0;
    count_sweep("rst_sweep");
    check("rst_no_disp", disp_req, 0);

    do_instr(OpLoad, 4'd3, 4'd0, 4'd0, 7'd100, 3, 16'd100);
    flags(16'd100, 1'b0, 1'b0);
    ack();

    // Build r1=0x7FFF from 64*64*8-1 (that SUBI itself overflows).
    do_instr(OpLoad, 4'd6, 4'd0, 4'd0, 7'd64, 3, 16'd64); ack();
    do_instr(OpMul, 4'd7, 4'd6, 4'd0, 7'd64, 5, 16'h1000); ack();
    do_instr(OpMul, 4'd7, 4'd7, 4'd0, 7'd8, 5, 16'h8000);
    flags(16'h8000, 1'b0, 1'b0); ack();
    do_instr(OpSubi, 4'd1, 4'd7, 4'd0, 7'd1, 5, 16'h7FFF);
    flags(16'h7FFF, 1'b1, 1'b0); ack();
    do_instr(OpLoad, 4'd2, 4'd0, 4'd0, 7'd1, 3, 16'd1); ack();
    do_instr(OpAdd, 4'd4, 4'd1, 4'd2, 7'd0, 6, 16'h8000);
    flags(16'h8000, 1'b1, 1'b0); ack();
    do_instr(OpDisplay, 4'd4, 4'd0, 4'd0, 7'd0, 2, 16'h8000);
    flags(16'h8000, 1'b1, 1'b0); ack();

    do_instr(OpLoad, 4'd2, 4'd0, 4'd0, 7'd125, 3, 16'd125); ack();
    do_instr(OpMul, 4'd2, 4'd2, 4'd0, 7'd8, 5, 16'd1000); ack();
    do_instr(OpMul, 4'd8, 4'd2, 4'd0, 7'd127, 5, 16'd61464);
    flags(16'd61464, 1'b1, 1'b0); ack();
    do_instr(OpLoad, 4'd2, 4'd0, 4'd0, 7'd100, 3, 16'd100); ack();
    do_instr(OpMul, 4'd2, 4'd2, 4'd0, 7'd3, 5, 16'd300); ack();
    do_instr(OpMul, 4'd9, 4'd2, 4'd0, 7'd127, 5, 16'd38100);
    flags(16'd38100, 1'b0, 1'b0); ack();

    do_instr(OpLoad, 4'd5, 4'd0, 4'd0, 7'd5, 3, 16'd5); ack();
    do_instr(OpSubi, 4'd10, 4'd5, 4'd0, 7'd5, 5, 16'd0);
    flags(16'd0, 1'b0, 1'b1); ack();
    do_instr(OpAdd, 4'd3, 4'd3, 4'd3, 7'd0, 6, 16'd200);
    flags(16'd200, 1'b0, 1'b0); ack();

    // CLEAR: accept, 16 sweep cycles, DISP_RD, capture, then request.
    do_instr(OpClear, 4'd4, 4'd0, 4'd0, 7'd0, 18, 16'd0);
    flags(16'd200, 1'b0, 1'b0); ack();
    do_instr(OpDisplay, 4'd9, 4'd0, 4'd0, 7'd0, 2, 16'd0); ack();

    // Abort while the display request is pending and unacknowledged.
    do_instr(OpLoad, 4'd3, 4'd0, 4'd0, 7'd7, 3, 16'd7);
    en = 1'b0;
    @(negedge clk);
    check("abort_req", disp_req, 0);
    check("abort_busy", busy, 1);
    check("abort_ready", instr_ready, 0);
    saw_req = 1'b0;
    n = 0;
    while (busy && n < 60) begin
      if (disp_req) saw_req = 1'b1;
      @(negedge clk);
      n++;
    end
    check("abort_sweep", n, 16);
    check("abort_no_disp", saw_req, 0);
    repeat (3) @(negedge clk);
    check("en0_ready", instr_ready, 0);
    check("en0_busy", busy, 0);
    flags(16'd7, 1'b0, 1'b0);
    en = 1'b1;
    #1;
    check("en1_ready", instr_ready, 1);
    @(negedge clk);
    do_instr(OpDisplay, 4'd3, 4'd0, 4'd0, 7'd0, 2, 16'd0); ack();

    // Reset takes priority over a pending display request.
    do_instr(OpLoad, 4'd2, 4'd0, 4'd0, 7'd9, 3, 16'd9);
    reset = 1'b1;
    @(negedge clk);
    check("rst2_req", disp_req, 0);
    check("rst2_busy", busy, 1);
    check("rst2_ddata", disp_data, 0);
    flags(16'd0, 1'b0, 1'b0);
    reset = 1'b0;
    count_sweep("rst2_sweep");
    do_instr(OpDisplay, 4'd2, 4'd0, 4'd0, 7'd0, 2, 16'd0); ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
